// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and bus constants shared by the GPIO controller.
package gpio_pkg;
  localparam int BUS_W = 32;
  localparam logic [7:0] GPIO_DATA_OUT   = 8'h00;
  localparam logic [7:0] GPIO_DIR        = 8'h04;
  localparam logic [7:0] GPIO_DATA_IN    = 8'h08;
  localparam logic [7:0] GPIO_IRQ_EN     = 8'h0C;
  localparam logic [7:0] GPIO_RISE_EN    = 8'h10;
  localparam logic [7:0] GPIO_FALL_EN    = 8'h14;
  localparam logic [7:0] GPIO_IRQ_STATUS = 8'h18;
  localparam logic [7:0] GPIO_SET        = 8'h1C;
  localparam logic [7:0] GPIO_CLR        = 8'h20;
endpackage

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: pad synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detection.
module gpio_in_cond #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] cond_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced, prev_q;
  assign synced = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= cond_o;
    end
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] cond_q;
  // cond follows synced only after DEB_CYCLES consecutive mismatching cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cond_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (synced[i] == cond_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          cnt_q[i]  <= '0;
          cond_q[i] <= synced[i];
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
    end
  assign cond_o = cond_q;
`else
  localparam int UNUSED_DEB = DEB_CYCLES;
  assign cond_o = synced;
`endif
  assign rise_o = cond_o & ~prev_q;
  assign fall_o = ~cond_o & prev_q;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO with direction, set/clear, W1C edge interrupts.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_q, out_d, dir_q, ien_q, ren_q, fen_q, st_q, st_d;
  logic [WIDTH-1:0] w, data_in, rise, fall;
  logic             irq_q;
  assign w = wdata[WIDTH-1:0];
  if (WIDTH < BUS_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^wdata[BUS_W-1:WIDTH];
  end
  gpio_in_cond #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_cond (
    .clk(clk), .reset(reset), .pin_i(gpio_in), .cond_o(data_in), .rise_o(rise), .fall_o(fall)
  );
  always_comb begin
    out_d = (we && addr == GPIO_DATA_OUT) ? w :
            (we && addr == GPIO_SET)      ? out_q | w :
            (we && addr == GPIO_CLR)      ? out_q & ~w : out_q;
    // a fresh edge overrides a simultaneous W1C on the same bit
    st_d  = (st_q & ~((we && addr == GPIO_IRQ_STATUS) ? w : '0)) | (rise & ren_q) | (fall & fen_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_q <= '0;
      dir_q <= '0;
      ien_q <= '0;
      ren_q <= '0;
      fen_q <= '0;
      st_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      out_q <= out_d;
      st_q  <= st_d;
      irq_q <= |(st_q & ien_q);
      if (we && addr == GPIO_DIR)     dir_q <= w;
      if (we && addr == GPIO_IRQ_EN)  ien_q <= w;
      if (we && addr == GPIO_RISE_EN) ren_q <= w;
      if (we && addr == GPIO_FALL_EN) fen_q <= w;
    end
  always_comb begin
    rdata = '0;
    case (addr)
      GPIO_DATA_OUT:   rdata = BUS_W'(out_q);
      GPIO_DIR:        rdata = BUS_W'(dir_q);
      GPIO_DATA_IN:    rdata = BUS_W'(data_in);
      GPIO_IRQ_EN:     rdata = BUS_W'(ien_q);
      GPIO_RISE_EN:    rdata = BUS_W'(ren_q);
      GPIO_FALL_EN:    rdata = BUS_W'(fen_q);
      GPIO_IRQ_STATUS: rdata = BUS_W'(st_q);
      default:         rdata = '0;
    endcase
  end
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed self-checking bench for gpio_ctrl (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_gpio_ctrl;
  localparam int WIDTH = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DL = 4;
`else
  localparam int DL = 0;
`endif
  localparam logic [7:0] A_OUT = 8'h00, A_DIR = 8'h04, A_IN = 8'h08, A_IEN = 8'h0C;
  localparam logic [7:0] A_REN = 8'h10, A_FEN = 8'h14, A_ST = 8'h18, A_SET = 8'h1C, A_CLR = 8'h20;
  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       addr;
  logic [31:0]      wdata;
  logic             we;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] gpio_in, gpio_out, gpio_oe;
  logic             irq;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [31:0]      rv;
  logic [7:0]       addrs [10];

  gpio_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
    addrs = '{A_OUT, A_DIR, A_IN, A_IEN, A_REN, A_FEN, A_ST, A_SET, A_CLR, 8'h24};
    tick(2);
    chk("rst_out", 32'(gpio_out), 0);
    chk("rst_oe", 32'(gpio_oe), 0);
    chk("rst_irq", 32'(irq), 0);
    reset = 1'b0;
    tick(1);
    foreach (addrs[i]) begin
      rd(addrs[i], rv);
      chk($sformatf("rst_rd_%0h", addrs[i]), rv, 0);
    end
    // data out, set, clear, width truncation
    wr(A_OUT, 32'h0F);  chk("out_wr", 32'(gpio_out), 32'h0F);
    wr(A_SET, 32'hA0);  chk("out_set", 32'(gpio_out), 32'hAF);
    wr(A_CLR, 32'h03);  chk("out_clr", 32'(gpio_out), 32'hAC);
    rd(A_SET, rv);      chk("rd_set_zero", rv, 0);
    wr(A_OUT, 32'h123); chk("out_trunc", 32'(gpio_out), 32'h23);
    rd(A_OUT, rv);      chk("rd_out", rv, 32'h23);
    wr(A_DIR, 32'h3C);  chk("oe", 32'(gpio_oe), 32'h3C);
    rd(A_DIR, rv);      chk("rd_dir", rv, 32'h3C);
    wr(A_IN, 32'hFF);   rd(A_IN, rv); chk("ro_in", rv, 0);
    // rise on bit0 with interrupt
    wr(A_REN, 32'h01); wr(A_IEN, 32'h01);
    gpio_in[0] = 1'b1;
    tick(1);    rd(A_IN, rv); chk("din_e1", rv, 0);
    tick(1+DL); rd(A_IN, rv); chk("din_e2", rv, 32'h01);
    rd(A_ST, rv); chk("st_e2", rv, 0);
    tick(1);    rd(A_ST, rv); chk("st_e3", rv, 32'h01);
    chk("irq_e3", 32'(irq), 0);
    tick(1);    chk("irq_e4", 32'(irq), 1);
    wr(A_ST, 32'h01); rd(A_ST, rv); chk("w1c_st", rv, 0);
    chk("irq_w1c_e1", 32'(irq), 1);
    tick(1);    chk("irq_w1c_e2", 32'(irq), 0);
    // fall on bit7, status latches with irq disabled
    gpio_in[7] = 1'b1;
    tick(4+DL);
    wr(A_IEN, 32'h00); wr(A_FEN, 32'h80);
    gpio_in[7] = 1'b0;
    tick(3+DL); rd(A_ST, rv); chk("fall_st", rv, 32'h80);
    chk("fall_irq_off", 32'(irq), 0);
    wr(A_IEN, 32'h80); chk("ien_same", 32'(irq), 0);
    tick(1);    chk("ien_next", 32'(irq), 1);
    // edge and W1C on bit2 in the same cycle
    wr(A_ST, 32'h80); wr(A_IEN, 32'h00); wr(A_REN, 32'h04);
    rd(A_ST, rv); chk("st_clean", rv, 0);
    gpio_in[2] = 1'b1;
    tick(2+DL);
    addr = A_ST; wdata = 32'h04; we = 1'b1;
    tick(1);
    we = 1'b0;
    rd(A_ST, rv); chk("set_wins", rv, 32'h04);
    wr(A_ST, 32'h04); rd(A_ST, rv); chk("w1c_bit2", rv, 0);
    // asynchronous reset with a pending irq
    wr(A_REN, 32'h02); wr(A_IEN, 32'h02); wr(A_OUT, 32'hFF);
    gpio_in[1] = 1'b1;
    tick(4+DL);
    chk("irq_pending", 32'(irq), 1);
    chk("out_ff", 32'(gpio_out), 32'hFF);
    #2 reset = 1'b1;
    #1 chk("async_out", 32'(gpio_out), 0);
    chk("async_irq", 32'(irq), 0);
    rd(A_ST, rv); chk("async_st", rv, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(5+DL);
    rd(A_ST, rv); chk("post_rst_st", rv, 0);
    rd(A_IN, rv); chk("post_rst_din", rv, 32'h07);
`ifdef GPIO_DEBOUNCE_EN
    wr(A_REN, 32'h08);
    gpio_in[3] = 1'b1;
    tick(3);
    gpio_in[3] = 1'b0;
    tick(10);
    rd(A_IN, rv); chk("glitch_din", rv, 32'h07);
    rd(A_ST, rv); chk("glitch_st", rv, 0);
    gpio_in[3] = 1'b1;
    tick(5);  rd(A_IN, rv); chk("deb_din_5", rv, 32'h07);
    tick(1);  rd(A_IN, rv); chk("deb_din_6", rv, 32'h0F);
    gpio_in[3] = 1'b0;
    rd(A_ST, rv); chk("deb_st_6", rv, 0);
    tick(1);  rd(A_ST, rv); chk("deb_st_7", rv, 32'h08);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
